display_scanner: RTL and testbench

- Read-side consumer of display_memory. Continuously scans the front buffer and drives a HUB75-style LED panel with two simultaneously-driven halves (rgb0 = upper half, rgb1 = lower half).
- Uses binary-code-modulated bit planes for colour depth.
- Owns the `flip` select of display_memory and performs buffer swaps only at frame boundaries, on request from the writer side.

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scanner.sv | 137 +++++++++++++
 tb/tb_display_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and pixel helpers for the display_scanner HUB75 panel driver.
package display_pkg;

    typedef enum logic [2:0] {
        READ_TOP,
        READ_BOT,
        SETUP,
        CLOCK,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    // Bit planes are taken from the channel MSBs: plane p reads ch[8-bits+p].
    function automatic logic [2:0] plane_slice(input logic [23:0] pixel,
                                               input int          plane,
                                               input int          bits);
        int idx;
        idx = 8 - bits + plane;
        return {pixel[5'(R_MSB - 7 + idx)],
                pixel[5'(G_MSB - 7 + idx)],
                pixel[5'(B_MSB - 7 + idx)]};
    endfunction

endpackage

// File: rtl/display_scanner.sv
// Scans the display_memory front buffer into a two-half HUB75 panel using
// binary-code-modulated bit planes; swaps buffers only at frame boundaries.
module display_scanner
    import display_pkg::*;
#(
    parameter int rows      = 16,
    parameter int columns   = 32,
    parameter int bits      = 8,
    parameter int base_time = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         flip,
    output logic [$clog2(rows)-1:0]      rrow,
    output logic [$clog2(columns)-1:0]   rcol,
    input  logic [23:0]                  rdata,
    output logic                         panel_clk,
    output logic                         panel_lat,
    output logic                         panel_oe_n,
    output logic [$clog2(rows/2)-1:0]    panel_addr,
    output logic [2:0]                   panel_rgb0,
    output logic [2:0]                   panel_rgb1
);

    localparam int half = rows / 2;
    localparam int RW   = $clog2(rows);
    localparam int CW   = $clog2(columns);
    localparam int HW   = $clog2(half);
    localparam int PW   = (bits > 1) ? $clog2(bits) : 1;
    localparam int TW   = $clog2((base_time << (bits - 1)) + 1);

    state_t          state, state_next;
    logic [CW-1:0]   col;
    logic [HW-1:0]   row;
    logic [PW-1:0]   plane;
    logic [TW-1:0]   timer;
    logic [23:0]     top_q;
    logic            swap_pending;

    logic last_col, last_plane, last_row, disp_done, frame_end;

    assign last_col   = (col == CW'(columns - 1));
    assign last_plane = (plane == PW'(bits - 1));
    assign last_row   = (row == HW'(half - 1));
    assign disp_done  = (state == DISPLAY) && (timer == '0);
    assign frame_end  = disp_done && last_plane && last_row;

    // The top-half pixel is addressed in READ_TOP, the bottom-half one in READ_BOT.
    assign rrow = (state == READ_BOT) ? RW'(row) + RW'(half) : RW'(row);
    assign rcol = col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= READ_TOP;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            READ_TOP: state_next = READ_BOT;
            READ_BOT: state_next = SETUP;
            SETUP:    state_next = CLOCK;
            CLOCK:    state_next = last_col ? BLANK : READ_TOP;
            BLANK:    state_next = LATCH;
            LATCH:    state_next = DISPLAY;
            DISPLAY:  state_next = (timer == '0) ? READ_TOP : DISPLAY;
            default:  state_next = READ_TOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            plane <= '0;
            timer <= '0;
            top_q <= '0;
        end else begin
            if (state == CLOCK)
                col <= last_col ? '0 : col + CW'(1);
            if (state == READ_BOT)
                top_q <= rdata;
            // Timer counts down to zero, so DISPLAY lasts exactly base_time<<plane cycles.
            if (state == LATCH)
                timer <= TW'((base_time << plane) - 1);
            else if (state == DISPLAY && timer != '0)
                timer <= timer - TW'(1);
            if (disp_done) begin
                if (last_plane) begin
                    plane <= '0;
                    row   <= last_row ? '0 : row + HW'(1);
                end else begin
                    plane <= plane + PW'(1);
                end
            end
        end
    end

    // NOTE: panel strobes are registered from state_next so they align with the
    // state they belong to while staying glitch-free at the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            panel_clk    <= 1'b0;
            panel_lat    <= 1'b0;
            panel_oe_n   <= 1'b1;
            panel_addr   <= '0;
            panel_rgb0   <= '0;
            panel_rgb1   <= '0;
            flip         <= 1'b0;
            swap_ack     <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            panel_clk  <= (state == CLOCK);
            panel_lat  <= (state_next == LATCH);
            panel_oe_n <= (state_next != DISPLAY);
            if (state_next == LATCH)
                panel_addr <= row;
            if (state == SETUP) begin
                panel_rgb0 <= plane_slice(top_q, int'(plane), bits);
                panel_rgb1 <= plane_slice(rdata, int'(plane), bits);
            end
            swap_ack <= 1'b0;
            if (frame_end) begin
                if (swap_pending || swap_req) begin
                    flip     <= ~flip;
                    swap_ack <= 1'b1;
                end
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a cycle-indexed timeline model of the
// scan (segment arithmetic per row/plane) plus a swap/flip model and memory model.
module tb_display_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int BITS = 2;
    localparam int BASE = 1;
    localparam int HALF = ROWS / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        flip;
    logic [1:0]  rrow;
    logic [1:0]  rcol;
    logic [23:0] rdata = '0;
    logic        panel_clk;
    logic        panel_lat;
    logic        panel_oe_n;
    logic [0:0]  panel_addr;
    logic [2:0]  panel_rgb0;
    logic [2:0]  panel_rgb1;

    display_scanner #(
        .rows(ROWS), .columns(COLS), .bits(BITS), .base_time(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .swap_ack(swap_ack),
        .flip(flip), .rrow(rrow), .rcol(rcol), .rdata(rdata),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr), .panel_rgb0(panel_rgb0), .panel_rgb1(panel_rgb1)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [ROWS][COLS];
    always @(posedge clk) rdata <= mem[rrow][rcol];

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_flip = 1'b0;
    bit exp_ack  = 1'b0;
    bit pend     = 1'b0;
    bit rand_req = 1'b0;
    int req_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int seg_len(input int p);
        return COLS * 4 + 2 + (BASE << p);
    endfunction

    function automatic int frame_len();
        int n = 0;
        for (int p = 0; p < BITS; p++) n += seg_len(p);
        return n * HALF;
    endfunction

    // Expected {R,G,B} for one plane, derived from channel values arithmetically.
    function automatic logic [2:0] ref_bits(input logic [23:0] pix, input int p);
        int b, r, g, bl;
        b  = 8 - BITS + p;
        r  = (int'(pix) / 65536) % 256;
        g  = (int'(pix) / 256) % 256;
        bl = int'(pix) % 256;
        return {1'((r >> b) & 1), 1'((g >> b) & 1), 1'((bl >> b) & 1)};
    endfunction

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1 rst_n = 1'b0;
        swap_req = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rst_oe_n", panel_oe_n, 1);
            check("rst_clk", panel_clk, 0);
            check("rst_lat", panel_lat, 0);
            check("rst_flip", flip, 0);
            check("rst_ack", swap_ack, 0);
            check("rst_rrow", rrow, 0);
            check("rst_rcol", rcol, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_flip = 1'b0;
        exp_ack  = 1'b0;
        pend     = 1'b0;
    endtask

    // Cycle k counts from the first cycle after reset release; rst_at >= 0 asserts
    // reset asynchronously in the middle of that cycle and abandons the run.
    task automatic run_scan(input int n, input int rst_at);
        for (int k = 0; k < n; k++) begin
            int o, r, p;
            bit req, clk_e;
            @(negedge clk);
            o = k % frame_len();
            r = 0;
            p = 0;
            while (o >= seg_len(p)) begin
                o -= seg_len(p);
                p++;
                if (p == BITS) begin
                    p = 0;
                    r++;
                end
            end
            clk_e = (o >= 4) && (o <= COLS * 4) && (o % 4 == 0);
            check("oe_n", panel_oe_n, (o >= COLS * 4 + 2) ? 0 : 1);
            check("lat", panel_lat, (o == COLS * 4 + 1) ? 1 : 0);
            check("panel_clk", panel_clk, clk_e);
            if (o < COLS * 4 && o % 4 == 0) begin
                check("rrow_top", rrow, r);
                check("rcol_top", rcol, o / 4);
            end
            if (o < COLS * 4 && o % 4 == 1) begin
                check("rrow_bot", rrow, r + HALF);
                check("rcol_bot", rcol, o / 4);
            end
            if (o == COLS * 4 + 1)
                check("panel_addr", panel_addr, r);
            if (clk_e) begin
                check("rgb0", panel_rgb0, ref_bits(mem[r][o/4-1], p));
                check("rgb1", panel_rgb1, ref_bits(mem[r+HALF][o/4-1], p));
            end
            check("flip", flip, exp_flip);
            check("swap_ack", swap_ack, exp_ack);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("async_oe_n", panel_oe_n, 1);
                check("async_flip", flip, 0);
                swap_req = 1'b0;
                return;
            end
            req = rand_req && ($urandom_range(39) == 0);
            foreach (req_q[i]) if (req_q[i] == k) req = 1'b1;
            swap_req = req;
            if (k % frame_len() == frame_len() - 1) begin
                exp_ack = pend || req;
                if (exp_ack) exp_flip = ~exp_flip;
                pend = 1'b0;
            end else begin
                exp_ack = 1'b0;
                pend = pend || req;
            end
        end
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = (r == 0) ? 24'h800000 : (r == HALF) ? 24'h008000 : 24'h0;

        // Directed data path plus swap scenarios: mid-frame, double, frame-end cycle.
        do_reset(3);
        req_q = '{30, 85, 100, 233};
        run_scan(320, -1);

        // Pending swap discarded by reset.
        do_reset(2);
        req_q = '{20};
        run_scan(50, -1);
        do_reset(2);
        req_q.delete();
        run_scan(170, -1);

        // Asynchronous reset during the first DISPLAY cycle.
        do_reset(2);
        run_scan(40, 18);
        do_reset(2);
        run_scan(30, -1);

        // Randomised pixels and swap requests.
        rand_req = 1'b1;
        repeat (3) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] = 24'($urandom);
            do_reset(2);
            run_scan(240, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
